// File: rtl/moxie_wb_prefetch.sv
// Wishbone classic instruction-prefetch master: DEPTH-entry sequential word queue with
// branch redirect. Optional bus-error halting is enabled by defining MOXIE_PREFETCH_ERR_EN.
module moxie_wb_prefetch #(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                DEPTH      = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR = 'h0000_1000
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    output logic [ADDR_W-1:0]       wb_adr_o,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic                    wb_we_o,
    output logic [DATA_W/8-1:0]     wb_sel_o,
    input  logic [DATA_W-1:0]       wb_dat_i,
    input  logic                    wb_ack_i,
    input  logic                    wb_err_i,
    input  logic                    flush_i,
    input  logic [ADDR_W-1:0]       flush_addr_i,
    input  logic                    ready_i,
    output logic                    valid_o,
    output logic [DATA_W-1:0]       word_o,
    output logic [ADDR_W-1:0]       addr_o,
    output logic                    err_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic [1:0]              dbg_state_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(DATA_W / 8);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DRAIN = 2'd2
`ifdef MOXIE_PREFETCH_ERR_EN
        , S_HALT = 2'd3
`endif
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_fetch_addr;
    logic [ADDR_W-1:0] r_adr;
    logic              r_cyc;

    logic [DATA_W-1:0] r_word [DEPTH];
    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;

    logic w_bus_err;
    logic w_term;
    logic w_push;
    logic w_pop;
    logic w_not_full;

`ifdef MOXIE_PREFETCH_ERR_EN
    logic r_err [DEPTH];
    assign w_bus_err = wb_err_i;
`else
    logic w_unused_err;
    assign w_bus_err    = 1'b0;
    assign w_unused_err = wb_err_i;
`endif

    // An error terminates the cycle just like an ack; it wins if both arrive together.
    assign w_term     = wb_ack_i | w_bus_err;
    assign w_push     = (r_state == S_REQ) && w_term && !flush_i;
    assign w_pop      = (r_count != '0) && ready_i && !flush_i;
    assign w_not_full = (r_count < CNT_FULL);

    assign wb_adr_o    = r_adr;
    assign wb_cyc_o    = r_cyc;
    assign wb_stb_o    = r_cyc;
    assign wb_we_o     = 1'b0;
    assign wb_sel_o    = '1;
    assign dbg_state_o = r_state;

    assign valid_o = (r_count != '0);
    assign word_o  = r_word[r_rd_ptr];
    assign addr_o  = r_addr[r_rd_ptr];
    assign count_o = r_count;
`ifdef MOXIE_PREFETCH_ERR_EN
    assign err_o = r_err[r_rd_ptr];
`else
    assign err_o = 1'b0;
`endif

    // Bus FSM: one outstanding classic cycle; cyc/stb/adr are registered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_cyc        <= 1'b0;
            r_adr        <= RESET_ADDR;
            r_fetch_addr <= RESET_ADDR;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (flush_i) begin
                        r_fetch_addr <= flush_addr_i;
                    end else if (w_not_full) begin
                        r_state <= S_REQ;
                        r_cyc   <= 1'b1;
                        r_adr   <= r_fetch_addr;
                    end
                end
                S_REQ: begin
                    if (flush_i) begin
                        r_fetch_addr <= flush_addr_i;
                        if (w_term) begin
                            r_cyc   <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_DRAIN;
                        end
                    end else if (w_term) begin
                        r_cyc        <= 1'b0;
                        r_fetch_addr <= r_adr + ADDR_STEP;
`ifdef MOXIE_PREFETCH_ERR_EN
                        r_state      <= w_bus_err ? S_HALT : S_IDLE;
`else
                        r_state      <= S_IDLE;
`endif
                    end
                end
                S_DRAIN: begin
                    // Stale cycle must still complete on the bus; its data is dropped.
                    if (flush_i) begin
                        r_fetch_addr <= flush_addr_i;
                    end
                    if (w_term) begin
                        r_cyc   <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
`ifdef MOXIE_PREFETCH_ERR_EN
                S_HALT: begin
                    if (flush_i) begin
                        r_fetch_addr <= flush_addr_i;
                        r_state      <= S_IDLE;
                    end
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                    r_cyc   <= 1'b0;
                end
            endcase
        end
    end

    // Circular queue; flush empties it and overrides any pop or push that cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_word[i] <= '0;
                r_addr[i] <= '0;
`ifdef MOXIE_PREFETCH_ERR_EN
                r_err[i]  <= 1'b0;
`endif
            end
        end else if (flush_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_word[r_wr_ptr] <= w_bus_err ? '0 : wb_dat_i;
                r_addr[r_wr_ptr] <= r_adr;
`ifdef MOXIE_PREFETCH_ERR_EN
                r_err[r_wr_ptr]  <= w_bus_err;
`endif
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_moxie_wb_prefetch.sv
// Bench for moxie_wb_prefetch: directed vector table, hand-written error/reset sequences,
// then randomized bus/consumer/flush traffic checked against a queue-level reference model.
module tb_moxie_wb_prefetch;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] wb_adr_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_i = '0;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [31:0] flush_addr_i = '0;
    logic        ready_i = 1'b0;
    logic        valid_o;
    logic [31:0] word_o;
    logic [31:0] addr_o;
    logic        err_o;
    logic [2:0]  count_o;
    logic [1:0]  dbg_state_o;

    int n_checks = 0;
    int n_fail   = 0;

    moxie_wb_prefetch dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .wb_adr_o(wb_adr_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_sel_o(wb_sel_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
        .flush_i(flush_i), .flush_addr_i(flush_addr_i), .ready_i(ready_i),
        .valid_o(valid_o), .word_o(word_o), .addr_o(addr_o), .err_o(err_o),
        .count_o(count_o), .dbg_state_o(dbg_state_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        ack;
        logic        ready;
        logic        flush;
        logic [31:0] faddr;
        logic        e_stb;
        logic [31:0] e_adr;
        logic        e_valid;
        logic [2:0]  e_cnt;
        logic [31:0] e_head;
    } vec_t;

    vec_t tv[$];

    function automatic logic [31:0] memword(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Inputs are applied just after a falling edge; outputs are sampled at the next one.
    task automatic step(input logic a, input logic e, input logic r, input logic f,
                        input logic [31:0] fa);
        wb_ack_i     = a;
        wb_err_i     = e;
        ready_i      = r;
        flush_i      = f;
        flush_addr_i = fa;
        wb_dat_i     = memword(wb_adr_o);
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic add_v(input logic a, input logic r, input logic f, input logic [31:0] fa,
                         input logic es, input logic [31:0] ea, input logic ev,
                         input logic [2:0] ec, input logic [31:0] eh);
        vec_t v;
        v.ack = a; v.ready = r; v.flush = f; v.faddr = fa;
        v.e_stb = es; v.e_adr = ea; v.e_valid = ev; v.e_cnt = ec; v.e_head = eh;
        tv.push_back(v);
    endtask

    task automatic check_reset_state(input string nm);
        chk({nm, "_stb"}, {31'd0, wb_stb_o}, 32'd0);
        chk({nm, "_cyc"}, {31'd0, wb_cyc_o}, 32'd0);
        chk({nm, "_adr"}, wb_adr_o, 32'h0000_1000);
        chk({nm, "_valid"}, {31'd0, valid_o}, 32'd0);
        chk({nm, "_count"}, {29'd0, count_o}, 32'd0);
        chk({nm, "_err"}, {31'd0, err_o}, 32'd0);
        chk({nm, "_word"}, word_o, 32'd0);
        chk({nm, "_addr"}, addr_o, 32'd0);
        chk({nm, "_we"}, {31'd0, wb_we_o}, 32'd0);
        chk({nm, "_sel"}, {28'd0, wb_sel_o}, 32'hF);
    endtask

    task automatic do_reset(input string nm);
        rst_i = 1'b1;
        step(0, 0, 0, 0, 0);
        check_reset_state(nm);
        step(0, 0, 0, 0, 0);
        rst_i = 1'b0;
    endtask

    logic [31:0] exp_q[$];
    logic [31:0] exp_next;
    bit          stale;
    int          pushes;

    initial begin
        logic        pre_stb;
        logic [31:0] pre_adr;
        logic [2:0]  pre_cnt;
        logic        a, r, f;
        logic [31:0] fa;
        int          ready_bias;

        // ack ready flush faddr | stb adr valid count head
        add_v(1, 1, 0, 0,            1, 32'h1000, 0, 0, 0);
        add_v(1, 1, 0, 0,            0, 0,        1, 1, 32'h1000);
        add_v(1, 1, 0, 0,            1, 32'h1004, 0, 0, 0);
        add_v(1, 1, 0, 0,            0, 0,        1, 1, 32'h1004);
        add_v(1, 1, 0, 0,            1, 32'h1008, 0, 0, 0);
        add_v(1, 1, 0, 0,            0, 0,        1, 1, 32'h1008);
        add_v(1, 0, 0, 0,            1, 32'h100C, 1, 1, 32'h1008);
        add_v(1, 0, 0, 0,            0, 0,        1, 2, 32'h1008);
        add_v(1, 0, 0, 0,            1, 32'h1010, 1, 2, 32'h1008);
        add_v(1, 0, 0, 0,            0, 0,        1, 3, 32'h1008);
        add_v(1, 0, 0, 0,            1, 32'h1014, 1, 3, 32'h1008);
        add_v(1, 0, 0, 0,            0, 0,        1, 4, 32'h1008);
        add_v(1, 0, 0, 0,            0, 0,        1, 4, 32'h1008);
        add_v(1, 0, 0, 0,            0, 0,        1, 4, 32'h1008);
        add_v(0, 1, 0, 0,            0, 0,        1, 3, 32'h100C);
        add_v(0, 0, 0, 0,            1, 32'h1018, 1, 3, 32'h100C);
        add_v(1, 0, 0, 0,            0, 0,        1, 4, 32'h100C);
        add_v(0, 0, 0, 0,            0, 0,        1, 4, 32'h100C);
        add_v(0, 1, 0, 0,            0, 0,        1, 3, 32'h1010);
        add_v(0, 0, 0, 0,            1, 32'h101C, 1, 3, 32'h1010);
        add_v(1, 1, 1, 32'h2000,     0, 0,        0, 0, 0);
        add_v(0, 0, 0, 0,            1, 32'h2000, 0, 0, 0);
        add_v(1, 0, 0, 0,            0, 0,        1, 1, 32'h2000);
        add_v(0, 0, 0, 0,            1, 32'h2004, 1, 1, 32'h2000);
        add_v(0, 0, 1, 32'h2400,     1, 32'h2004, 0, 0, 0);
        add_v(0, 0, 0, 0,            1, 32'h2004, 0, 0, 0);
        add_v(0, 0, 1, 32'h2800,     1, 32'h2004, 0, 0, 0);
        add_v(1, 0, 0, 0,            0, 0,        0, 0, 0);
        add_v(0, 0, 0, 0,            1, 32'h2800, 0, 0, 0);
        add_v(1, 0, 0, 0,            0, 0,        1, 1, 32'h2800);
        add_v(0, 0, 1, 32'hFFFF_FFF8, 0, 0,       0, 0, 0);
        add_v(0, 0, 0, 0,            1, 32'hFFFF_FFF8, 0, 0, 0);
        add_v(1, 0, 0, 0,            0, 0,        1, 1, 32'hFFFF_FFF8);
        add_v(0, 0, 0, 0,            1, 32'hFFFF_FFFC, 1, 1, 32'hFFFF_FFF8);
        add_v(1, 0, 0, 0,            0, 0,        1, 2, 32'hFFFF_FFF8);
        add_v(0, 0, 0, 0,            1, 32'h0000_0000, 1, 2, 32'hFFFF_FFF8);
        add_v(1, 0, 0, 0,            0, 0,        1, 3, 32'hFFFF_FFF8);
        add_v(0, 1, 1, 32'h1000,     0, 0,        0, 0, 0);
        add_v(0, 1, 0, 0,            1, 32'h1000, 0, 0, 0);

        @(negedge clk_i);
        do_reset("rst0");

        for (int i = 0; i < tv.size(); i++) begin
            step(tv[i].ack, 0, tv[i].ready, tv[i].flush, tv[i].faddr);
            chk($sformatf("v%0d_stb", i), {31'd0, wb_stb_o}, {31'd0, tv[i].e_stb});
            chk($sformatf("v%0d_cyc", i), {31'd0, wb_cyc_o}, {31'd0, tv[i].e_stb});
            if (tv[i].e_stb) chk($sformatf("v%0d_adr", i), wb_adr_o, tv[i].e_adr);
            chk($sformatf("v%0d_valid", i), {31'd0, valid_o}, {31'd0, tv[i].e_valid});
            chk($sformatf("v%0d_count", i), {29'd0, count_o}, {29'd0, tv[i].e_cnt});
            chk($sformatf("v%0d_err", i), {31'd0, err_o}, 32'd0);
            if (tv[i].e_valid) begin
                chk($sformatf("v%0d_head", i), addr_o, tv[i].e_head);
                chk($sformatf("v%0d_word", i), word_o, memword(tv[i].e_head));
            end
        end

        // Reset while a bus cycle is open must drop cyc/stb at that edge.
        do_reset("rst_mid");

        // Bus error on the third fetch (0x1008).
        step(0, 0, 0, 0, 0);
        chk("e_stb0", {31'd0, wb_stb_o}, 32'd1);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("e_adr2", wb_adr_o, 32'h1008);
        step(0, 1, 0, 0, 0);
`ifdef MOXIE_PREFETCH_ERR_EN
        chk("e_stb_after_err", {31'd0, wb_stb_o}, 32'd0);
        chk("e_cnt_after_err", {29'd0, count_o}, 32'd3);
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 0, 0);
            chk("e_halt_stb", {31'd0, wb_stb_o}, 32'd0);
        end
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("e_head_addr", addr_o, 32'h1008);
        chk("e_head_err", {31'd0, err_o}, 32'd1);
        chk("e_head_word", word_o, 32'd0);
        step(0, 0, 0, 1, 32'h3000);
        chk("e_flush_valid", {31'd0, valid_o}, 32'd0);
        step(0, 0, 0, 0, 0);
        chk("e_resume_stb", {31'd0, wb_stb_o}, 32'd1);
        chk("e_resume_adr", wb_adr_o, 32'h3000);
`else
        chk("e_stb_held", {31'd0, wb_stb_o}, 32'd1);
        chk("e_adr_held", wb_adr_o, 32'h1008);
        chk("e_cnt_unchanged", {29'd0, count_o}, 32'd2);
        chk("e_err_tied", {31'd0, err_o}, 32'd0);
        step(1, 0, 0, 0, 0);
        chk("e_cnt_after_ack", {29'd0, count_o}, 32'd3);
        step(0, 0, 0, 0, 0);
        chk("e_next_adr", wb_adr_o, 32'h100C);
`endif

        // Randomized traffic against the queue-level reference model.
        do_reset("rst_rand");
        exp_q.delete();
        exp_next   = 32'h0000_1000;
        stale      = 0;
        pushes     = 0;
        ready_bias = 2;
        for (int c = 0; c < 3000; c++) begin
            pre_stb = wb_stb_o;
            pre_adr = wb_adr_o;
            pre_cnt = count_o;
            if (c % 500 == 0) ready_bias = $urandom_range(0, 4);
            a  = pre_stb ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 3) == 0);
            r  = ($urandom_range(0, 3) < ready_bias);
            f  = ($urandom_range(0, 39) == 0);
            fa = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom_range(0, 3) << 2))
                                             : ($urandom() & 32'hFFFF_FFFC);
            step(a, 0, r, f, fa);

            if (f) begin
                exp_q.delete();
                exp_next = fa;
                stale    = pre_stb && !a;
            end else begin
                if (r && exp_q.size() != 0) void'(exp_q.pop_front());
                if (pre_stb && a) begin
                    if (stale) begin
                        stale = 0;
                    end else begin
                        exp_q.push_back(exp_next);
                        exp_next = exp_next + 32'd4;
                        pushes++;
                    end
                end
            end

            chk("r_valid", {31'd0, valid_o}, {31'd0, exp_q.size() != 0});
            chk("r_count", {29'd0, count_o}, exp_q.size());
            chk("r_cyc_stb", {31'd0, wb_cyc_o}, {31'd0, wb_stb_o});
            if (exp_q.size() != 0) begin
                chk("r_head", addr_o, exp_q[0]);
                chk("r_word", word_o, memword(exp_q[0]));
            end
            if (wb_stb_o && !pre_stb) begin
                chk("r_req_adr", wb_adr_o, exp_next);
                chk("r_slot_free", {31'd0, pre_cnt < 3'd4}, 32'd1);
            end else if (wb_stb_o && pre_stb) begin
                chk("r_adr_stable", wb_adr_o, pre_adr);
            end
        end
        chk("r_progress", {31'd0, pushes > 100}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
